multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset; one clock domain only.
REQ-002 SHALL have inputs: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; mem_ready  in  1  memory access completes this cycle; zero  in  1  ALU zero flag.
REQ-003 SHALL have outputs: pc_write  out  1; pc_src  out  2  (0 ALU result, 1 ALUOut branch target, 2 jump target); ir_write  out  1; iord  out  1  (0 PC, 1 ALUOut address).
REQ-004 SHALL have outputs: mem_read  out  1; mem_write  out  1; mem_to_reg  out  1; reg_dst  out  1; reg_write  out  1.
REQ-005 SHALL have outputs: alu_src_a  out  1  (0 PC, 1 regA); alu_src_b  out  2  (0 regB, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2); alu_control  out  4.
REQ-006 SHALL have outputs: illegal  out  1  sticky trap flag; retire  out  1  one-cycle instruction-complete pulse; retired_cnt  out  16; state  out  4  debug.

Function
REQ-007 SHALL be a Moore FSM; every output SHALL be a function of the state register and latched decode only, except pc_write/ir_write in FETCH and BRANCH (see below).
REQ-008 SHALL encode states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12; codes 13-15 SHALL go to TRAP.
REQ-009 SHALL drive alu_control: add=4'h2, sub=4'h6, and=4'h0, or=4'h1, slt=4'h7; all strobes SHALL default to 0 in any state not setting them.
REQ-010 FETCH SHALL drive iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_control=2; ir_write=pc_write=mem_ready, pc_src=0; SHALL move to DECODE only when mem_ready=1, else hold.
REQ-011 DECODE SHALL drive alu_src_a=0, alu_src_b=3, alu_control=2, and SHALL latch the R-type ALU op from funct into an internal register.
REQ-012 DECODE transitions: opcode 0x23/0x2B->MEMADR; 0x00 with funct 0x20/0x22/0x24/0x25/0x2A->EXEC; 0x04->BRANCH; 0x02->JUMP; 0x08->ADDIEX; any other opcode or funct->TRAP.
REQ-013 MEMADR SHALL drive alu_src_a=1, alu_src_b=2, alu_control=2; next MEMRD for 0x23, MEMWR for 0x2B.
REQ-014 MEMRD SHALL drive iord=1, mem_read=1; SHALL hold until mem_ready=1, then MEMWB.
REQ-015 MEMWB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-016 MEMWR SHALL drive iord=1, mem_write=1 held steady until mem_ready=1, then FETCH.
REQ-017 EXEC SHALL drive alu_src_a=1, alu_src_b=0, alu_control=latched op; next ALUWB, which SHALL drive reg_dst=1, reg_write=1, mem_to_reg=0; next FETCH.
REQ-018 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_control=6, pc_src=1, pc_write=zero; next FETCH regardless of zero.
REQ-019 JUMP SHALL drive pc_src=2, pc_write=1; next FETCH.
REQ-020 ADDIEX SHALL drive alu_src_a=1, alu_src_b=2, alu_control=2; next ADDIWB, which SHALL drive reg_dst=0, reg_write=1; next FETCH.
REQ-021 TRAP SHALL hold all strobes 0, illegal=1, and remain until rst.
REQ-022 retire SHALL pulse for exactly one cycle on the final state of each instruction (MEMWB, MEMWR with mem_ready, ALUWB, BRANCH, JUMP, ADDIWB); retired_cnt SHALL increment on retire and wrap 0xFFFF->0x0000.
REQ-023 Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-024 mem_ready SHALL be ignored in every state except FETCH, MEMRD, MEMWR.

Reset
REQ-025 When rst=1 at a rising edge, state SHALL become FETCH, illegal 0, retired_cnt 0, latched ALU op 4'h2.
REQ-026 While rst=1, all outputs SHALL be forced to 0 (state output shows 0), including mid-access in MEMRD/MEMWR; no write strobe may be asserted.

Verification
REQ-027 Reset, then lw (0x23), mem_ready=1 -> states 0,1,2,3,4; reg_write=1 and mem_to_reg=1 only in cycle 5; retired_cnt=1.
REQ-028 sw with mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 cycles, iord=1 throughout, then FETCH.
REQ-029 beq with zero=1 then zero=0 -> pc_write=1, pc_src=1 in first BRANCH; pc_write=0 in second.
REQ-030 R-type funct 0x2A -> alu_control=7 in EXEC; funct 0x03 -> TRAP, illegal=1 until rst.
REQ-031 rst asserted in MEMRD -> next cycle state=0, all strobes 0; retired_cnt forced 0xFFFF+1 retire -> 0x0000.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        zero;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic        illegal;
    logic        retire;
    logic [15:0] retired_cnt;
    logic [3:0]  state;

    modport master (
        input  opcode, funct, mem_ready, zero,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_control, illegal,
               retire, retired_cnt, state
    );

    modport slave (
        output opcode, funct, mem_ready, zero,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_control, illegal,
               retire, retired_cnt, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style multicycle MIPS-subset controller with sticky illegal-op trap
// and a retired-instruction counter.
module multicycle_control (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StTrap   = 4'd12
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        store_q;
    logic        illegal_q;
    logic [15:0] cnt_q;
    logic        retire;

    always_comb begin
        unique case (bus.funct)
            6'h20:   alu_op_d = 4'h2;
            6'h22:   alu_op_d = 4'h6;
            6'h24:   alu_op_d = 4'h0;
            6'h25:   alu_op_d = 4'h1;
            6'h2A:   alu_op_d = 4'h7;
            default: alu_op_d = 4'h2;
        endcase
    end

    // Decode-time facts are latched so later states never look at the IR fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            alu_op_q  <= 4'h2;
            store_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                alu_op_q <= alu_op_d;
                store_q  <= (bus.opcode == 6'h2B);
            end
            if (state_d == StTrap) illegal_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d         = state_q;
        retire          = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'd0;
        bus.ir_write    = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'd0;
        bus.alu_control = 4'h0;
        unique case (state_q)
            StFetch: begin
                bus.mem_read    = 1'b1;
                bus.alu_src_b   = 2'd1;
                bus.alu_control = 4'h2;
                bus.ir_write    = bus.mem_ready;
                bus.pc_write    = bus.mem_ready;
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                bus.alu_src_b   = 2'd3;
                bus.alu_control = 4'h2;
                unique case (bus.opcode)
                    6'h23, 6'h2B: state_d = StMemAdr;
                    6'h00: state_d = (bus.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
                                     ? StExec : StTrap;
                    6'h04:   state_d = StBranch;
                    6'h02:   state_d = StJump;
                    6'h08:   state_d = StAddiEx;
                    default: state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'd2;
                bus.alu_control = 4'h2;
                state_d         = store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                retire         = 1'b1;
                state_d        = StFetch;
            end
            StMemWr: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExec: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = alu_op_q;
                state_d         = StAluWb;
            end
            StAluWb: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = 4'h6;
                bus.pc_src      = 2'd1;
                bus.pc_write    = bus.zero;
                retire          = 1'b1;
                state_d         = StFetch;
            end
            StJump: begin
                bus.pc_src   = 2'd2;
                bus.pc_write = 1'b1;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            StAddiEx: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'd2;
                bus.alu_control = 4'h2;
                state_d         = StAddiWb;
            end
            StAddiWb: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase

        bus.retire      = retire;
        bus.illegal     = illegal_q;
        bus.retired_cnt = cnt_q;
        bus.state       = state_q;

        // Reset masks every output immediately, even mid memory access.
        if (rst) begin
            bus.pc_write    = 1'b0;
            bus.pc_src      = 2'd0;
            bus.ir_write    = 1'b0;
            bus.iord        = 1'b0;
            bus.mem_read    = 1'b0;
            bus.mem_write   = 1'b0;
            bus.mem_to_reg  = 1'b0;
            bus.reg_dst     = 1'b0;
            bus.reg_write   = 1'b0;
            bus.alu_src_a   = 1'b0;
            bus.alu_src_b   = 2'd0;
            bus.alu_control = 4'h0;
            bus.retire      = 1'b0;
            bus.illegal     = 1'b0;
            bus.retired_cnt = 16'h0000;
            bus.state       = 4'd0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls,
// reset mid-access, counter wrap and the illegal-op trap.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_control, retire, illegal}
    function automatic logic [18:0] strobes();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read,
                bus.mem_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.retire, bus.illegal};
    endfunction

    // Apply one cycle of inputs after the falling edge; outputs settle by #1.
    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic mr, input logic z);
        @(negedge clk);
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = mr;
        bus.zero      = z;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 6'h23, 6'h20, 1'b1, 1'b1);
        drive(1'b1, 6'h23, 6'h20, 1'b1, 1'b1);
        if (strobes() !== 19'h0) begin
            $display("FAIL reset_strobes: got %h want 0", strobes()); errors++;
        end
        checks++;
        if (bus.state !== 4'd0 || bus.retired_cnt !== 16'h0) begin
            $display("FAIL reset_state_cnt: got %0d/%h want 0/0", bus.state, bus.retired_cnt);
            errors++;
        end
        checks++;
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd0 || bus.mem_read !== 1'b1 || bus.alu_src_b !== 2'd1 ||
            bus.alu_control !== 4'h2 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
            $display("FAIL fetch_idle: got st=%0d rd=%b b=%0d alu=%h irw=%b pcw=%b want 0 1 1 2 0 0",
                     bus.state, bus.mem_read, bus.alu_src_b, bus.alu_control, bus.ir_write,
                     bus.pc_write);
            errors++;
        end
        checks++;
        if (bus.illegal !== 1'b0) begin
            $display("FAIL reset_illegal: got %b want 0", bus.illegal); errors++;
        end
        checks++;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 6'h23, 6'h00, 1'b1, 1'b0);
            if (bus.state !== exp_st[c]) begin
                $display("FAIL lw_state[%0d]: got %0d want %0d", c, bus.state, exp_st[c]);
                errors++;
            end
            checks++;
            if (bus.reg_write !== (c == 4) || bus.mem_to_reg !== (c == 4) ||
                bus.retire !== (c == 4) || bus.iord !== (c == 3) || bus.ir_write !== (c == 0)) begin
                $display("FAIL lw_strobes[%0d]: got rw=%b m2r=%b ret=%b iord=%b irw=%b", c,
                         bus.reg_write, bus.mem_to_reg, bus.retire, bus.iord, bus.ir_write);
                errors++;
            end
            checks++;
        end
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd0 || bus.retired_cnt !== 16'd1) begin
            $display("FAIL lw_done: got st=%0d cnt=%0d want 0 1", bus.state, bus.retired_cnt);
            errors++;
        end
        checks++;
    endtask

    task automatic test_sw_stall();
        logic       mrs    [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 6'h2B, 6'h00, mrs[c], 1'b0);
            if (bus.state !== exp_st[c]) begin
                $display("FAIL sw_state[%0d]: got %0d want %0d", c, bus.state, exp_st[c]);
                errors++;
            end
            checks++;
            if (bus.mem_write !== (c >= 3) || bus.iord !== (c >= 3) || bus.retire !== (c == 6)) begin
                $display("FAIL sw_strobes[%0d]: got mw=%b iord=%b ret=%b", c, bus.mem_write,
                         bus.iord, bus.retire);
                errors++;
            end
            checks++;
        end
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd0 || bus.retired_cnt !== 16'd2) begin
            $display("FAIL sw_done: got st=%0d cnt=%0d want 0 2", bus.state, bus.retired_cnt);
            errors++;
        end
        checks++;
    endtask

    task automatic test_beq();
        drive(1'b0, 6'h04, 6'h00, 1'b1, 1'b1);
        drive(1'b0, 6'h04, 6'h00, 1'b1, 1'b1);
        drive(1'b0, 6'h04, 6'h00, 1'b1, 1'b1);
        if (bus.state !== 4'd8 || bus.pc_write !== 1'b1 || bus.pc_src !== 2'd1 ||
            bus.alu_control !== 4'h6 || bus.retire !== 1'b1) begin
            $display("FAIL beq_taken: got st=%0d pcw=%b src=%0d alu=%h ret=%b want 8 1 1 6 1",
                     bus.state, bus.pc_write, bus.pc_src, bus.alu_control, bus.retire);
            errors++;
        end
        checks++;
        drive(1'b0, 6'h04, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h04, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h04, 6'h00, 1'b1, 1'b0);
        if (bus.state !== 4'd8 || bus.pc_write !== 1'b0 || bus.pc_src !== 2'd1 ||
            bus.retire !== 1'b1) begin
            $display("FAIL beq_not_taken: got st=%0d pcw=%b src=%0d ret=%b want 8 0 1 1",
                     bus.state, bus.pc_write, bus.pc_src, bus.retire);
            errors++;
        end
        checks++;
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd0 || bus.retired_cnt !== 16'd4) begin
            $display("FAIL beq_done: got st=%0d cnt=%0d want 0 4", bus.state, bus.retired_cnt);
            errors++;
        end
        checks++;
    endtask

    task automatic test_rtype_addi_jump();
        logic [3:0] exp_r [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [3:0] exp_a [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 6'h00, 6'h2A, 1'b1, 1'b0);
            if (bus.state !== exp_r[c]) begin
                $display("FAIL rtype_state[%0d]: got %0d want %0d", c, bus.state, exp_r[c]);
                errors++;
            end
            checks++;
            if (c == 2 && (bus.alu_control !== 4'h7 || bus.alu_src_a !== 1'b1 ||
                           bus.alu_src_b !== 2'd0)) begin
                $display("FAIL rtype_exec: got alu=%h a=%b b=%0d want 7 1 0", bus.alu_control,
                         bus.alu_src_a, bus.alu_src_b);
                errors++;
            end
            if (c == 3 && (bus.reg_dst !== 1'b1 || bus.reg_write !== 1'b1 ||
                           bus.mem_to_reg !== 1'b0 || bus.retire !== 1'b1)) begin
                $display("FAIL rtype_wb: got rd=%b rw=%b m2r=%b ret=%b want 1 1 0 1",
                         bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.retire);
                errors++;
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 6'h08, 6'h00, 1'b1, 1'b0);
            if (bus.state !== exp_a[c]) begin
                $display("FAIL addi_state[%0d]: got %0d want %0d", c, bus.state, exp_a[c]);
                errors++;
            end
            checks++;
            if (c == 2 && (bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'd2 ||
                           bus.alu_control !== 4'h2)) begin
                $display("FAIL addi_ex: got a=%b b=%0d alu=%h want 1 2 2", bus.alu_src_a,
                         bus.alu_src_b, bus.alu_control);
                errors++;
            end
            if (c == 3 && (bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 ||
                           bus.retire !== 1'b1)) begin
                $display("FAIL addi_wb: got rw=%b rd=%b ret=%b want 1 0 1", bus.reg_write,
                         bus.reg_dst, bus.retire);
                errors++;
            end
        end
        drive(1'b0, 6'h02, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h02, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h02, 6'h00, 1'b1, 1'b0);
        if (bus.state !== 4'd9 || bus.pc_src !== 2'd2 || bus.pc_write !== 1'b1 ||
            bus.retire !== 1'b1) begin
            $display("FAIL jump: got st=%0d src=%0d pcw=%b ret=%b want 9 2 1 1", bus.state,
                     bus.pc_src, bus.pc_write, bus.retire);
            errors++;
        end
        checks++;
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd0 || bus.retired_cnt !== 16'd7) begin
            $display("FAIL rtype_addi_jump_done: got st=%0d cnt=%0d want 0 7", bus.state,
                     bus.retired_cnt);
            errors++;
        end
        checks++;
    endtask

    task automatic test_rst_in_memrd();
        drive(1'b0, 6'h23, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h23, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h23, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
        drive(1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd3 || bus.mem_read !== 1'b1 || bus.iord !== 1'b1) begin
            $display("FAIL memrd_hold: got st=%0d rd=%b iord=%b want 3 1 1", bus.state,
                     bus.mem_read, bus.iord);
            errors++;
        end
        checks++;
        drive(1'b1, 6'h23, 6'h00, 1'b1, 1'b0);
        if (strobes() !== 19'h0 || bus.state !== 4'd0) begin
            $display("FAIL rst_memrd_mask: got %h st=%0d want 0 0", strobes(), bus.state);
            errors++;
        end
        checks++;
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd0 || bus.retired_cnt !== 16'd0 || bus.mem_write !== 1'b0) begin
            $display("FAIL rst_memrd_after: got st=%0d cnt=%0d mw=%b want 0 0 0", bus.state,
                     bus.retired_cnt, bus.mem_write);
            errors++;
        end
        checks++;
    endtask

    task automatic test_wrap();
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        #1;
        if (bus.retired_cnt !== 16'hFFFF) begin
            $display("FAIL wrap_preload: got %h want ffff", bus.retired_cnt); errors++;
        end
        checks++;
        drive(1'b0, 6'h02, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h02, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h02, 6'h00, 1'b1, 1'b0);
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.retired_cnt !== 16'h0000 || bus.state !== 4'd0) begin
            $display("FAIL wrap: got cnt=%h st=%0d want 0000 0", bus.retired_cnt, bus.state);
            errors++;
        end
        checks++;
    endtask

    task automatic test_trap();
        drive(1'b0, 6'h00, 6'h03, 1'b1, 1'b0);
        drive(1'b0, 6'h00, 6'h03, 1'b1, 1'b0);
        drive(1'b0, 6'h00, 6'h03, 1'b1, 1'b0);
        if (bus.state !== 4'd12 || strobes() !== 19'h1) begin
            $display("FAIL trap_enter: got st=%0d strobes=%h want 12 1", bus.state, strobes());
            errors++;
        end
        checks++;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 6'h23, 6'h20, 1'b1, 1'b1);
            if (bus.state !== 4'd12 || bus.illegal !== 1'b1 || bus.mem_read !== 1'b0) begin
                $display("FAIL trap_hold[%0d]: got st=%0d ill=%b rd=%b want 12 1 0", c,
                         bus.state, bus.illegal, bus.mem_read);
                errors++;
            end
            checks++;
        end
        drive(1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
        if (strobes() !== 19'h0 || bus.state !== 4'd0) begin
            $display("FAIL trap_rst: got %h st=%0d want 0 0", strobes(), bus.state);
            errors++;
        end
        checks++;
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin
            $display("FAIL trap_cleared: got st=%0d ill=%b want 0 0", bus.state, bus.illegal);
            errors++;
        end
        checks++;
    endtask

    initial begin
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype_addi_jump();
        test_rst_in_memrd();
        test_wrap();
        test_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
